// File: rtl/pipe_add.sv
// pipe_add: pipelined WIDTH-bit add/subtract with carry, signed-overflow and zero flags.
// Define PIPE_ADD_SAT_EN to add i_sat, which clamps signed overflow in the last stage.
module pipe_add #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_sub,
`ifdef PIPE_ADD_SAT_EN
    input  logic             i_sat,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_out,
    output logic             o_carry,
    output logic             o_ovf,
    output logic             o_zero
);
    localparam int C = (WIDTH + STAGES - 1) / STAGES;

    logic w_adv;
    assign w_adv   = !o_valid || i_ready;
    assign o_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = (k * C < WIDTH) ? k * C : WIDTH;
        localparam int HI = (LO + C < WIDTH) ? LO + C : WIDTH;
        localparam int KB = (HI < WIDTH - 1) ? HI : WIDTH - 1;
        localparam logic [WIDTH-1:0] M = WIDTH'(((WIDTH + 1)'(1) << HI) - ((WIDTH + 1)'(1) << LO));

        logic             w_v;
        logic             w_c;
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH-1:0] w_s;
        logic [WIDTH-1:0] w_sum;
        logic [HI:0]      w_t;
`ifdef PIPE_ADD_SAT_EN
        logic             w_sat;
`endif

        if (k == 0) begin : g_in
            assign w_v = i_valid;
            assign w_c = i_sub;
            assign w_a = i_op1;
            assign w_b = i_sub ? ~i_op2 : i_op2;
            assign w_s = '0;
`ifdef PIPE_ADD_SAT_EN
            assign w_sat = i_sat;
`endif
        end else begin : g_in
            // upper operand bits kept from the previous stage always include the MSB
            localparam int PB = (LO < WIDTH - 1) ? LO : WIDTH - 1;
            assign w_v = g_st[k-1].g_mid.r_v;
            assign w_c = g_st[k-1].g_mid.r_c;
            assign w_a = {g_st[k-1].g_mid.r_a, {PB{1'b0}}};
            assign w_b = {g_st[k-1].g_mid.r_b, {PB{1'b0}}};
            assign w_s = g_st[k-1].g_mid.r_s;
`ifdef PIPE_ADD_SAT_EN
            assign w_sat = g_st[k-1].g_mid.r_sat;
`endif
        end

        assign w_t   = (HI + 1)'({1'b0, w_a & M} + {1'b0, w_b & M} + ((WIDTH + 1)'(w_c) << LO));
        assign w_sum = w_s | WIDTH'(w_t[HI-1:0] & M[HI-1:0]);

        if (k < STAGES - 1) begin : g_mid
            logic              r_v;
            logic              r_c;
            logic [WIDTH-1:0]  r_s;
            logic [WIDTH-1:KB] r_a;
            logic [WIDTH-1:KB] r_b;
`ifdef PIPE_ADD_SAT_EN
            logic              r_sat;
`endif
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_v <= 1'b0;
                    r_c <= 1'b0;
                    r_s <= '0;
                    r_a <= '0;
                    r_b <= '0;
`ifdef PIPE_ADD_SAT_EN
                    r_sat <= 1'b0;
`endif
                end else if (w_adv) begin
                    r_v <= w_v;
                    r_c <= w_t[HI];
                    r_s <= w_sum;
                    r_a <= w_a[WIDTH-1:KB];
                    r_b <= w_b[WIDTH-1:KB];
`ifdef PIPE_ADD_SAT_EN
                    r_sat <= w_sat;
`endif
                end
            end
        end else begin : g_last
            logic             w_ovf;
            logic [WIDTH-1:0] w_res;
            logic             r_v;
            logic             r_c;
            logic             r_ovf;
            logic             r_z;
            logic [WIDTH-1:0] r_s;

            assign w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
`ifdef PIPE_ADD_SAT_EN
            assign w_res = (w_sat && w_ovf) ? {w_a[WIDTH-1], {(WIDTH-1){!w_a[WIDTH-1]}}} : w_sum;
`else
            assign w_res = w_sum;
`endif

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_v   <= 1'b0;
                    r_c   <= 1'b0;
                    r_ovf <= 1'b0;
                    r_z   <= 1'b0;
                    r_s   <= '0;
                end else if (w_adv) begin
                    r_v   <= w_v;
                    r_c   <= w_t[HI];
                    r_ovf <= w_ovf;
                    r_z   <= (w_res == '0);
                    r_s   <= w_res;
                end
            end

            assign o_valid = r_v;
            assign o_out   = r_s;
            assign o_carry = r_c;
            assign o_ovf   = r_ovf;
            assign o_zero  = r_z;
        end
    end
endmodule

// File: tb/tb_pipe_add.sv
// tb_pipe_add: directed and randomized checks of pipe_add (32/2, 8/3 and 64/8 configurations).
module tb_pipe_add;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_sub, i_ready, i_sat;
    logic [31:0] op1, op2;
    logic        o_ready, o_valid, o_carry, o_ovf, o_zero;
    logic [31:0] o_out;

    logic        v8, s8, r8, ordy8, ov8, c8, f8, z8;
    logic [7:0]  a8, b8, out8;
    logic        v64, s64, r64, ordy64, ov64, c64, f64, z64;
    logic [63:0] a64, b64, out64;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_add #(.WIDTH(32), .STAGES(2)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_op1(op1), .i_op2(op2), .i_sub(i_sub),
`ifdef PIPE_ADD_SAT_EN
        .i_sat(i_sat),
`endif
        .o_valid(o_valid), .i_ready(i_ready), .o_out(o_out),
        .o_carry(o_carry), .o_ovf(o_ovf), .o_zero(o_zero)
    );

    pipe_add #(.WIDTH(8), .STAGES(3)) u_d8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(ordy8),
        .i_op1(a8), .i_op2(b8), .i_sub(s8),
`ifdef PIPE_ADD_SAT_EN
        .i_sat(1'b0),
`endif
        .o_valid(ov8), .i_ready(r8), .o_out(out8),
        .o_carry(c8), .o_ovf(f8), .o_zero(z8)
    );

    pipe_add #(.WIDTH(64), .STAGES(8)) u_d64 (
        .i_clk(clk), .i_rst(rst), .i_valid(v64), .o_ready(ordy64),
        .i_op1(a64), .i_op2(b64), .i_sub(s64),
`ifdef PIPE_ADD_SAT_EN
        .i_sat(1'b0),
`endif
        .o_valid(ov64), .i_ready(r64), .o_out(out64),
        .o_carry(c64), .o_ovf(f64), .o_zero(z64)
    );

    task automatic chk(input string tag, input logic [66:0] got, input logic [66:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [66:0] ref_f(input int w, input logic [63:0] a, input logic [63:0] b, input logic sub);
        logic [64:0] m, s;
        logic [63:0] bb, o;
        logic        ov;
        m  = (65'd1 << w) - 65'd1;
        bb = sub ? (~b & m[63:0]) : b;
        s  = {1'b0, a} + {1'b0, bb} + 65'(sub);
        o  = s[63:0] & m[63:0];
        ov = (a[w-1] == bb[w-1]) && (o[w-1] != a[w-1]);
        return {o, s[w], ov, o == 64'd0};
    endfunction

    task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic sat, input logic [31:0] eo, input logic ec, input logic ev, input logic ez);
        @(posedge clk); #1;
        i_valid = 1'b1; op1 = a; op2 = b; i_sub = sub; i_sat = sat; i_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, 67'(o_ready), 67'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk({tag, "_lat"}, 67'(o_valid), 67'd0);
        @(posedge clk); #1;
        chk({tag, "_vld"}, 67'(o_valid), 67'd1);
        chk({tag, "_out"}, 67'(o_out), 67'(eo));
        chk({tag, "_c"}, 67'(o_carry), 67'(ec));
        chk({tag, "_v"}, 67'(o_ovf), 67'(ev));
        chk({tag, "_z"}, 67'(o_zero), 67'(ez));
    endtask

    initial begin
        logic [31:0] prev_out;
        logic        held;
        logic [66:0] q8[$], q64[$];
        int nxt, rcv;
        rst = 1'b1; i_valid = 1'b0; i_sub = 1'b0; i_ready = 1'b1; i_sat = 1'b0; op1 = '0; op2 = '0;
        v8 = 1'b0; s8 = 1'b0; r8 = 1'b1; a8 = '0; b8 = '0;
        v64 = 1'b0; s64 = 1'b0; r64 = 1'b1; a64 = '0; b64 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_v", 67'(o_valid), 67'd0);
        chk("rst_out", 67'(o_out), 67'd0);
        chk("rst_flags", 67'({o_carry, o_ovf, o_zero}), 67'd0);
        chk("rst_rdy", 67'(o_ready), 67'd1);

        run1("add5_7", 32'd5, 32'd7, 1'b0, 1'b0, 32'd12, 1'b0, 1'b0, 1'b0);
        run1("addwrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        run1("addovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run1("sub5_3", 32'd5, 32'd3, 1'b1, 1'b0, 32'd2, 1'b1, 1'b0, 1'b0);
        run1("sub3_5", 32'd3, 32'd5, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run1("subovf", 32'h8000_0000, 32'd1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`ifdef PIPE_ADD_SAT_EN
        run1("satpos", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run1("satneg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`endif

        // stream of 6 beats; even beats add 100+n + 3n, odd beats subtract 100+n - 3n
        nxt = 0; rcv = 0; held = 1'b0; prev_out = '0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            @(posedge clk); #1;
            i_ready = !(cyc >= 4 && cyc < 7);
            i_valid = (nxt < 6);
            op1 = 32'(100 + nxt); op2 = 32'(3 * nxt); i_sub = nxt[0];
            #1;
            if (o_valid && !i_ready) chk("stall_rdy", 67'(o_ready), 67'd0);
            if (held) chk("hold_out", 67'({o_out, o_carry, o_ovf, o_zero}), 67'({prev_out, rcv[0], 1'b0, 1'b0}));
            if (o_valid && i_ready) begin
                chk("stream_out", 67'({o_out, o_carry}), 67'({32'(rcv[0] ? 100 - 2 * rcv : 100 + 4 * rcv), rcv[0]}));
                rcv++;
            end
            if (i_valid && o_ready) nxt++;
            held = o_valid && !i_ready;
            prev_out = o_out;
        end
        chk("stream_cnt", 67'(rcv), 67'd6);
        i_valid = 1'b0; i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("stream_dup", 67'(o_valid), 67'd0);

        // reset with two beats in flight: one held at the output, one in stage 0
        @(posedge clk); #1;
        i_ready = 1'b0; i_valid = 1'b1; op1 = 32'hFFFF_FFFF; op2 = 32'd1; i_sub = 1'b0;
        @(posedge clk); #1;
        op1 = 32'd20; op2 = 32'd22;
        @(posedge clk); #1;
        chk("fl_held", 67'(o_valid), 67'd1);
        i_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; i_ready = 1'b1;
        chk("fl_v", 67'(o_valid), 67'd0);
        chk("fl_out", 67'({o_out, o_carry, o_ovf, o_zero}), 67'd0);
        #1 chk("fl_rdy", 67'(o_ready), 67'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("fl_stale", 67'(o_valid), 67'd0);
        end
        run1("post_rst", 32'd9, 32'd9, 1'b0, 1'b0, 32'd18, 1'b0, 1'b0, 1'b0);

        // random beats with random backpressure on the 8/3 and 64/8 configurations
        for (int cyc = 0; cyc < 1200; cyc++) begin
            @(posedge clk); #1;
            r8 = ($urandom_range(0, 3) != 0); v8 = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
            r64 = ($urandom_range(0, 3) != 0); v64 = ($urandom_range(0, 3) != 0);
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; s64 = 1'($urandom);
            if (cyc % 50 == 0) begin a8 = 8'h7F; b8 = 8'h01; s8 = 1'b0; a64 = 64'h8000_0000_0000_0000; b64 = 64'd1; s64 = 1'b1; end
            if (cyc >= 1150) begin v8 = 1'b0; v64 = 1'b0; r8 = 1'b1; r64 = 1'b1; end
            #1;
            if (ov8 && r8) begin
                if (q8.size() == 0) chk("r8_extra", 67'd1, 67'd0);
                else chk("r8", {56'd0, out8, c8, f8, z8}, q8.pop_front());
            end
            if (ov64 && r64) begin
                if (q64.size() == 0) chk("r64_extra", 67'd1, 67'd0);
                else chk("r64", {out64, c64, f64, z64}, q64.pop_front());
            end
            if (v8 && ordy8) q8.push_back(ref_f(8, 64'(a8), 64'(b8), s8));
            if (v64 && ordy64) q64.push_back(ref_f(64, a64, b64, s64));
        end
        chk("r8_left", 67'(q8.size()), 67'd0);
        chk("r64_left", 67'(q64.size()), 67'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
